// File: rtl/bus_memory.sv
// CPU memory-port responder: word RAM, GPIO and cycle-counter registers, sub-word lane alignment.
// Optional feature macro: MISALIGN_TRAP_EN (suppress misaligned stores, raise sticky bus_error).
module bus_memory #(
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   input  logic [3:0]  byteMask,
   input  logic        memWrite,
   output logic [31:0] memReadData,
   output logic [7:0]  gpio_out,
   output logic        bus_error
);

   logic [31:0]          mem_r [0:MEM_WORDS-1];
   logic [31:0]          cnt_r;
   logic [7:0]           gpio_r;
   logic [31:0]          rdata_r;
   logic                 sel_ram_s;
   logic                 sel_gpio_s;
   logic                 sel_cnt_s;
   logic [1:0]           offset_s;
   logic [ADDR_BITS-1:0] word_idx_s;
   logic [31:0]          word_view_s;
   logic [31:0]          read_next_s;
   logic [31:0]          wdata_s;
   logic [3:0]           wmask_s;
   logic                 store_en_s;

   // Address decode and offset extraction
   always_comb begin
      sel_ram_s  = ~memAddress[31];
      sel_gpio_s = (memAddress == 32'h8000_0000);
      sel_cnt_s  = (memAddress == 32'h8000_0004);
      offset_s   = memAddress[1:0];
      word_idx_s = memAddress[ADDR_BITS+1:2];
   end

   // Word view of the selected target; CNT is presented byte-reversed
   always_comb begin
      word_view_s = 32'h0000_0000;
      if (sel_ram_s) begin
         word_view_s = mem_r[word_idx_s];
      end else if (sel_gpio_s) begin
         word_view_s = {gpio_r, 24'h00_0000};
      end else if (sel_cnt_s) begin
         word_view_s = {cnt_r[7:0], cnt_r[15:8], cnt_r[23:16], cnt_r[31:24]};
      end else begin
         word_view_s = 32'h0000_0000;
      end
      read_next_s = word_view_s << {offset_s, 3'b000};
   end

   // Store alignment: lane L lands in word lane L-offset; lanes below offset fall off
   always_comb begin
      wdata_s = memWriteData >> {offset_s, 3'b000};
      wmask_s = byteMask >> offset_s;
   end

`ifdef MISALIGN_TRAP_EN
   logic misaligned_s;
   logic bus_error_r;

   // Misaligned word or halfword store is squashed entirely
   always_comb begin
      misaligned_s = 1'b0;
      if ((byteMask == 4'b1111) && (offset_s != 2'b00)) begin
         misaligned_s = 1'b1;
      end else if ((byteMask == 4'b1100) && offset_s[0]) begin
         misaligned_s = 1'b1;
      end else begin
         misaligned_s = 1'b0;
      end
      store_en_s = memWrite & ~misaligned_s;
   end

   // Sticky misalignment flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_error_r <= 1'b0;
      end else if (memWrite && misaligned_s) begin
         bus_error_r <= 1'b1;
      end else begin
         bus_error_r <= bus_error_r;
      end
   end

   assign bus_error = bus_error_r;
`else
   // Misaligned stores simply keep their in-word bytes
   always_comb begin
      store_en_s = memWrite;
   end

   assign bus_error = 1'b0;
`endif

   // RAM byte-lane writes; storage is deliberately not reset, but a store under reset is lost
   always_ff @(posedge clk) begin
      if (reset && store_en_s && sel_ram_s) begin
         for (int l = 0; l < 4; l++) begin
            if (wmask_s[l]) begin
               mem_r[word_idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
            end
         end
      end
   end

   // Registered read data, GPIO register and free-running counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_r <= 32'h0000_0000;
         gpio_r  <= 8'h00;
         cnt_r   <= 32'h0000_0000;
      end else begin
         rdata_r <= read_next_s;
         cnt_r   <= cnt_r + 32'h0000_0001;
         if (store_en_s && sel_gpio_s && wmask_s[3]) begin
            gpio_r <= wdata_s[31:24];
         end else begin
            gpio_r <= gpio_r;
         end
      end
   end

   assign memReadData = rdata_r;
   assign gpio_out    = gpio_r;

endmodule

// File: tb/tb_bus_memory.sv
// Directed scoreboard bench for bus_memory: expected read data is queued at drive time and
// checked one cycle later; MMIO, misalignment and async reset are checked inline.
module tb_bus_memory;

   logic        clk;
   logic        reset;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic [3:0]  byteMask;
   logic        memWrite;
   logic [31:0] memReadData;
   logic [7:0]  gpio_out;
   logic        bus_error;

   int          checks;
   int          errors;
   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [31:0] v1;
   logic [31:0] v2;

   bus_memory #(.MEM_WORDS(1024), .ADDR_BITS(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .byteMask     (byteMask),
      .memWrite     (memWrite),
      .memReadData  (memReadData),
      .gpio_out     (gpio_out),
      .bus_error    (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // One bus cycle; when chk is set the expected read data is scoreboarded
   task automatic step(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                       input logic we, input logic chk, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      string       t;
      memAddress   = addr;
      memWriteData = wd;
      byteMask     = mask;
      memWrite     = we;
      if (chk) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      if (chk) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, memReadData, e);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask);
      step(addr, wd, mask, 1'b1, 1'b0, 32'h0, "");
   endtask

   // Reads carry a stale byte-store mask to show it is ignored
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      step(addr, 32'h0, 4'b1000, 1'b0, 1'b1, exp, tag);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      memAddress   = 32'h0;
      memWriteData = 32'h0;
      byteMask     = 4'b0000;
      memWrite     = 1'b0;
      #2;
      check("reset_rdata", memReadData, 32'h0);
      check("reset_gpio", {24'h0, gpio_out}, 32'h0);
      check("reset_berr", {31'h0, bus_error}, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b1;

      wr(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
      rd(32'h0000_0010, 32'hDEAD_BEEF, "word_rt");
      rd(32'h0000_1010, 32'hDEAD_BEEF, "alias");
      wr(32'h0000_0012, 32'hAA00_0000, 4'b1000);
      rd(32'h0000_0010, 32'hDEAD_AAEF, "byte_store");
      rd(32'h0000_0013, 32'hEF00_0000, "byte_read");

      wr(32'h0000_0020, 32'h5566_7788, 4'b1111);
      wr(32'h0000_0022, 32'h1234_0000, 4'b1100);
      rd(32'h0000_0020, 32'h5566_1234, "half_store");
      rd(32'h0000_0022, 32'h1234_0000, "half_read");

      // Same-edge write and read returns old contents
      step(32'h0000_0010, 32'h0102_0304, 4'b1111, 1'b1, 1'b1, 32'hDEAD_AAEF, "rbw_old");
      rd(32'h0000_0010, 32'h0102_0304, "rbw_new");
      wr(32'h0000_0014, 32'hCAFE_F00D, 4'b0000);
      wr(32'h0000_0014, 32'h7777_7777, 4'b1111);
      wr(32'h0000_0014, 32'hCAFE_F00D, 4'b0000);
      rd(32'h0000_0014, 32'h7777_7777, "mask_zero_noop");

      wr(32'h8000_0000, 32'h5A00_0000, 4'b1000);
      check("gpio_out", {24'h0, gpio_out}, 32'h0000_005A);
      rd(32'h8000_0000, 32'h5A00_0000, "gpio_read");
      wr(32'h8000_0008, 32'hFFFF_FFFF, 4'b1111);
      rd(32'h8000_0008, 32'h0, "unmapped");
      check("gpio_unmapped_wr", {24'h0, gpio_out}, 32'h0000_005A);

      // Counter: reads k cycles apart differ by k
      step(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, "");
      v1 = memReadData;
      repeat (3) step(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, "");
      step(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, "");
      v2 = memReadData;
      check("cnt_delta", bswap(v2) - bswap(v1), 32'd4);
      wr(32'h8000_0004, 32'h0000_0000, 4'b1111);
      step(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, "");
      v1 = memReadData;
      check("cnt_write_ignored", bswap(v1) - bswap(v2), 32'd2);

      wr(32'h0000_0030, 32'h1122_3344, 4'b1111);
      wr(32'h0000_0031, 32'hAABB_CCDD, 4'b1111);
`ifdef MISALIGN_TRAP_EN
      rd(32'h0000_0030, 32'h1122_3344, "misalign_ram");
      check("misalign_berr", {31'h0, bus_error}, 32'h1);
      wr(32'h0000_0034, 32'h0000_0001, 4'b1111);
      check("misalign_sticky", {31'h0, bus_error}, 32'h1);
`else
      rd(32'h0000_0030, 32'h11AA_BBCC, "misalign_ram");
      check("misalign_berr", {31'h0, bus_error}, 32'h0);
      wr(32'h0000_0034, 32'h0000_0001, 4'b1111);
      check("misalign_sticky", {31'h0, bus_error}, 32'h0);
`endif

      // Asynchronous reset mid-stream; a store under reset is lost
      wr(32'h0000_0040, 32'h600D_600D, 4'b1111);
      rd(32'h0000_0010, 32'h0102_0304, "pre_reset");
      #2;
      reset = 1'b0;
      #1;
      check("async_rdata", memReadData, 32'h0);
      check("async_gpio", {24'h0, gpio_out}, 32'h0);
      check("async_berr", {31'h0, bus_error}, 32'h0);
      memAddress   = 32'h0000_0040;
      memWriteData = 32'hBAD0_BAD0;
      byteMask     = 4'b1111;
      memWrite     = 1'b1;
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      reset    = 1'b1;
      rd(32'h8000_0004, 32'h0000_0000, "cnt_restart0");
      rd(32'h8000_0004, 32'h0100_0000, "cnt_restart1");
      rd(32'h0000_0010, 32'h0102_0304, "ram_kept");
      rd(32'h0000_0040, 32'h600D_600D, "store_lost");
      check("gpio_after_reset", {24'h0, gpio_out}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_memory.md
# bus_memory

Bus responder on the far end of the CPU memory port. It accepts the CPU's address, write data, byte mask and write strobe, and returns registered read data. It holds a word-organised RAM plus two memory-mapped registers: GPIO output and a free-running cycle counter. It performs all sub-word lane alignment, so a byte or halfword always travels in the top lanes of the bus.

## Interface
Parameters:
- MEM_WORDS, default 1024: RAM depth in 32-bit words; must be a power of two.
- ADDR_BITS, default 10: log2(MEM_WORDS).

Ports:
- clk  in  1: single clock; all state changes on its rising edge.
- reset  in  1: asynchronous, active-low (0 = reset).
- memAddress  in  32: byte address of the access.
- memWriteData  in  32: store data in bus lane order. Lane 3 = [31:24] = byte at memAddress+0; lane 2 = [23:16] = byte at +1; and so on.
- byteMask  in  4: lanes to store. Bit 3 = lane 3. Legal values: 1000 (byte), 1100 (half), 1111 (word).
- memWrite  in  1: store strobe.
- memReadData  out  32: registered read data, in bus lane order.
- gpio_out  out  8: GPIO register.
- bus_error  out  1: sticky misaligned-store flag (only with the macro, see Configuration).

## Operation
- Decode:
  - memAddress[31]=0 selects RAM. Word index = memAddress[ADDR_BITS+1:2]; higher bits are ignored, so the RAM aliases.
  - 0x8000_0000 selects GPIO.
  - 0x8000_0004 selects CNT.
  - Any other address with bit31=1: reads return 0, writes are ignored.
- offset = memAddress[1:0].
- Word view W: the selected 32-bit word in lane order; lane 3 holds byte offset 0.
  - RAM: the stored word.
  - GPIO: {gpio_out, 24'b0}.
  - CNT: {cnt[7:0], cnt[15:8], cnt[23:16], cnt[31:24]}.
- Read path:
  - Next memReadData = W shifted toward lane 3 by 8*offset, zero-filled.
  - byteMask is ignored on reads. Fetches issue a stale mask, so every read returns the full shifted word.
- Write path, when memWrite=1:
  - Each lane L with byteMask[L]=1 targets byte offset + (3−L).
  - Targets beyond byte 3 are dropped.
  - byteMask=0000 is a no-op.
- Registers:
  - GPIO: only byte 0 exists. A write targeting byte 0 at GPIO loads gpio_out.
  - CNT: read-only. Increments by 1 every cycle out of reset, wraps from 0xFFFF_FFFF to 0.
- Misaligned store: a word store with offset≠0, or a half store with offset 1 or 3.

## Timing
- Read latency 1 cycle:
  - The address presented before edge N yields memReadData valid after edge N.
  - memReadData updates every cycle.
- Write and read at the same edge to the same word:
  - The read returns the old contents (read-before-write).
  - The write is visible on the next read.
- The CNT value read is the pre-increment value at the capturing edge.
- Reset (reset=0), asynchronous:
  - Outputs go to memReadData=0, gpio_out=0, bus_error=0.
  - cnt=0.
  - RAM contents are not reset.
  - Reset asserted during a store: the store is lost if reset is low at the edge.
- No handshake and no stalls: every access completes in one cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned store is suppressed entirely; no byte is written.
  - bus_error sets to 1 at that edge and stays 1 until reset.
- MISALIGN_TRAP_EN undefined:
  - A misaligned store writes its in-word bytes and drops the rest.
  - bus_error is tied to 0.

## Test plan
- Word round trip: store 0xDEADBEEF with mask 1111 at 0x10, then read 0x10 → memReadData=0xDEADBEEF one cycle after the address is presented; read 0x1010 (alias, ADDR_BITS=10) → 0xDEADBEEF.
- Byte lanes:
  - After the word store above, byte store memWriteData=0xAA000000, mask 1000 at 0x12 → read 0x10 gives 0xDEADAAEF.
  - Read 0x13 → 0xEF000000.
- Halfword read and write:
  - Store 0x12340000, mask 1100 at 0x22 → read 0x20 gives 0xXXXX1234, where the low lanes keep prior contents.
  - Read 0x22 → 0x12340000.
- MMIO:
  - Write 0x5A000000 with mask 1000 to 0x8000_0000 → gpio_out=0x5A.
  - Read 0x8000_0000 → 0x5A000000.
  - Two reads of 0x8000_0004 k cycles apart differ by k in byte-reversed order.
  - Write to 0x8000_0004 → cnt unaffected.
- Misalignment:
  - Word store at 0x31 with the macro: RAM unchanged, bus_error=1, and it stays 1 after subsequent good stores.
  - Without the macro: bytes 1–3 of word 0x30 are written and bus_error=0.
- Reset: assert reset mid-stream → memReadData, gpio_out and bus_error read 0 immediately without a clock edge; cnt restarts from 0; RAM data written before reset reads back intact.
